// File: rtl/vme_slave_if.sv
// VME slave-side bus bundle: VME cycle inputs, local 68030 arbitration, and RAM/buffer controls.
// All control signals are active low except vme_data_dir.
interface vme_slave_if;
    logic       vme_as;
    logic [1:0] vme_ds;
    logic       vme_lword;
    logic       vme_write;
    logic       vme_iack;
    logic [5:0] vme_address_mod;
    logic [3:0] vme_address_high;
    logic       vme_a1;
    logic       vme_dtack;
    logic       vme_berr;
    logic       cpu_as;
    logic       cpu_br;
    logic       cpu_bg;
    logic       cpu_bgack;
    logic [3:0] ram_ds;
    logic       ram_write;
    logic       vme_addr_in_oe;
    logic       vme_data_oe;
    logic       vme_data_dir;

    modport slave (
        input  vme_as, vme_ds, vme_lword, vme_write, vme_iack, vme_address_mod,
               vme_address_high, vme_a1, cpu_as, cpu_bg,
        output vme_dtack, vme_berr, cpu_br, cpu_bgack, ram_ds, ram_write,
               vme_addr_in_oe, vme_data_oe, vme_data_dir
    );

    modport master (
        output vme_as, vme_ds, vme_lword, vme_write, vme_iack, vme_address_mod,
               vme_address_high, vme_a1, cpu_as, cpu_bg,
        input  vme_dtack, vme_berr, cpu_br, cpu_bgack, ram_ds, ram_write,
               vme_addr_in_oe, vme_data_oe, vme_data_dir
    );
endinterface

// File: rtl/vme_slave_responder.sv
// VME A24 slave responder: decodes cycles into this card's window, borrows the local 68030 bus,
// strobes on-board RAM and answers with DTACK or BERR.
module vme_slave_responder #(
    parameter logic [3:0]  BASE_ADDR     = 4'h2,
    parameter int unsigned WAIT_STATES   = 2,
    parameter int unsigned GRANT_TIMEOUT = 64
) (
    input logic        clock,
    input logic        reset,
    vme_slave_if.slave bus
);
    localparam int unsigned CNT_MAX = (GRANT_TIMEOUT > WAIT_STATES) ? GRANT_TIMEOUT : WAIT_STATES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, REQUEST, WAIT_DS, ACCESS, ACK, RELEASE, ERROR, WAIT_AS_HIGH
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [3:0]         lane_q, lane_next, lane_c;
    logic               wr_q, wr_next, legal_c, sel_c, abort_c, as_fall_c;
    logic               as_meta, as_s, as_d;
    logic [1:0]         ds_meta, ds_s;

    logic       dtack_q, berr_q, br_q, bgack_q, ram_write_q, addr_oe_q, data_oe_q, data_dir_q;
    logic [3:0] ram_ds_q;
    logic       dtack_next, berr_next, br_next, bgack_next, ram_write_next;
    logic       addr_oe_next, data_oe_next, data_dir_next;
    logic [3:0] ram_ds_next;

    // Synchronizers reset to "asserted" so a strobe already low at reset release never looks like a new edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            as_meta <= 1'b0;
            as_s    <= 1'b0;
            as_d    <= 1'b0;
            ds_meta <= 2'b00;
            ds_s    <= 2'b00;
        end else begin
            as_meta <= bus.vme_as;
            as_s    <= as_meta;
            as_d    <= as_s;
            ds_meta <= bus.vme_ds;
            ds_s    <= ds_meta;
        end
    end

    assign as_fall_c = as_d && !as_s;
    assign abort_c   = as_s && (ds_s == 2'b11);
    assign sel_c     = (bus.vme_address_high == BASE_ADDR) && bus.vme_iack &&
                       (bus.vme_address_mod inside {6'h39, 6'h3A, 6'h3D, 6'h3E});

    // Byte-lane map and legality from the synced strobes.
    always_comb begin
        lane_c  = 4'hF;
        legal_c = 1'b1;
        if (!bus.vme_lword) begin
            lane_c  = 4'h0;
            legal_c = !bus.vme_a1 && (ds_s == 2'b00);
        end else if (!bus.vme_a1) begin
            lane_c = {ds_s, 2'b11};
        end else begin
            lane_c = {2'b11, ds_s};
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lane_next  = lane_q;
        wr_next    = wr_q;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (as_fall_c) state_next = sel_c ? REQUEST : WAIT_AS_HIGH;
            end
            REQUEST: begin
                if (abort_c) begin
                    state_next = IDLE;
                end else if (!bus.cpu_bg && bus.cpu_as) begin
                    state_next = WAIT_DS;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    state_next = ERROR;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_DS: begin
                if (abort_c) begin
                    state_next = IDLE;
                end else if (ds_s != 2'b11) begin
                    if (legal_c) begin
                        state_next = ACCESS;
                        lane_next  = lane_c;
                        wr_next    = bus.vme_write;
                        cnt_next   = '0;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
            ACCESS: begin
                if (abort_c) begin
                    state_next = IDLE;
                end else if (cnt == CNT_W'(WAIT_STATES - 1)) begin
                    // Master already dropped DS: finish the access but never acknowledge it.
                    state_next = (ds_s == 2'b11) ? RELEASE : ACK;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                if (abort_c)              state_next = IDLE;
                else if (ds_s == 2'b11)   state_next = RELEASE;
            end
            RELEASE:      state_next = WAIT_AS_HIGH;
            ERROR:        if (ds_s == 2'b11) state_next = WAIT_AS_HIGH;
            WAIT_AS_HIGH: if (as_s) state_next = IDLE;
            default:      state_next = IDLE;
        endcase

        // Outputs are a registered function of the state being entered.
        dtack_next     = 1'b1;
        berr_next      = 1'b1;
        br_next        = 1'b1;
        bgack_next     = 1'b1;
        ram_ds_next    = 4'hF;
        ram_write_next = 1'b1;
        addr_oe_next   = 1'b1;
        data_oe_next   = 1'b1;
        data_dir_next  = 1'b1;
        case (state_next)
            REQUEST: br_next = 1'b0;
            WAIT_DS: begin
                bgack_next   = 1'b0;
                addr_oe_next = 1'b0;
            end
            ACCESS, ACK: begin
                bgack_next     = 1'b0;
                addr_oe_next   = 1'b0;
                data_oe_next   = 1'b0;
                data_dir_next  = !wr_next;
                ram_ds_next    = lane_next;
                ram_write_next = wr_next;
                dtack_next     = (state_next != ACK);
            end
            ERROR:   berr_next = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lane_q      <= 4'hF;
            wr_q        <= 1'b1;
            dtack_q     <= 1'b1;
            berr_q      <= 1'b1;
            br_q        <= 1'b1;
            bgack_q     <= 1'b1;
            ram_ds_q    <= 4'hF;
            ram_write_q <= 1'b1;
            addr_oe_q   <= 1'b1;
            data_oe_q   <= 1'b1;
            data_dir_q  <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            lane_q      <= lane_next;
            wr_q        <= wr_next;
            dtack_q     <= dtack_next;
            berr_q      <= berr_next;
            br_q        <= br_next;
            bgack_q     <= bgack_next;
            ram_ds_q    <= ram_ds_next;
            ram_write_q <= ram_write_next;
            addr_oe_q   <= addr_oe_next;
            data_oe_q   <= data_oe_next;
            data_dir_q  <= data_dir_next;
        end
    end

    assign bus.vme_dtack      = dtack_q;
    assign bus.vme_berr       = berr_q;
    assign bus.cpu_br         = br_q;
    assign bus.cpu_bgack      = bgack_q;
    assign bus.ram_ds         = ram_ds_q;
    assign bus.ram_write      = ram_write_q;
    assign bus.vme_addr_in_oe = addr_oe_q;
    assign bus.vme_data_oe    = data_oe_q;
    assign bus.vme_data_dir   = data_dir_q;
endmodule

// File: tb/tb_vme_slave_responder.sv
// Bench for vme_slave_responder: directed VME cycles push expected DTACK/BERR responses into a
// queue; a negedge monitor pops and compares each response as the DUT asserts it.
module tb_vme_slave_responder;
    localparam int WS = 2;
    localparam int GT = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vme_slave_if bus ();

    vme_slave_responder #(
        .BASE_ADDR    (4'h2),
        .WAIT_STATES  (WS),
        .GRANT_TIMEOUT(GT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic       is_berr;
        logic [3:0] ram_ds;
        logic       ram_write;
        logic       data_dir;
        int         br_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   grant_delay = -1;
    logic activity = 1'b0;
    logic prev_dtack = 1'b1, prev_berr = 1'b1, prev_br = 1'b1;
    int   br_cnt = 0, strobe_cnt = 0;
    logic [11:0] outs;

    assign outs = {bus.vme_dtack, bus.vme_berr, bus.cpu_br, bus.cpu_bgack, bus.ram_ds,
                   bus.ram_write, bus.vme_addr_in_oe, bus.vme_data_oe, bus.vme_data_dir};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor / scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (outs != 12'hFFF) activity = 1'b1;
            if (bus.cpu_br == 1'b0) br_cnt = prev_br ? 1 : br_cnt + 1;
            if (!bus.vme_dtack && prev_dtack) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_dtack: got DTACK asserted, expected no response");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind_dtack", 32'(e.is_berr), 0);
                    check("ram_ds", 32'(bus.ram_ds), 32'(e.ram_ds));
                    check("ram_write", 32'(bus.ram_write), 32'(e.ram_write));
                    check("data_dir", 32'(bus.vme_data_dir), 32'(e.data_dir));
                    check("data_oe", 32'(bus.vme_data_oe), 0);
                    check("berr_with_dtack", 32'(bus.vme_berr), 1);
                    check("strobe_cycles", strobe_cnt, WS);
                    check("br_cycles", br_cnt, e.br_cycles);
                end
            end
            if (!bus.vme_berr && prev_berr) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_berr: got BERR asserted, expected no response");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind_berr", 32'(e.is_berr), 1);
                    check("dtack_with_berr", 32'(bus.vme_dtack), 1);
                    check("br_released", 32'(bus.cpu_br), 1);
                    check("bgack_released", 32'(bus.cpu_bgack), 1);
                    check("ram_ds_idle_on_berr", 32'(bus.ram_ds), 32'hF);
                    check("br_cycles", br_cnt, e.br_cycles);
                end
            end
            if (bus.ram_ds == 4'hF) strobe_cnt = 0;
            else if (bus.vme_dtack) strobe_cnt++;
        end
        prev_dtack = bus.vme_dtack;
        prev_berr  = bus.vme_berr;
        prev_br    = bus.cpu_br;
    end

    // Local 68030 arbiter model: grants grant_delay cycles after BR is seen low.
    initial begin : grant_model
        int n;
        n = 0;
        bus.cpu_bg = 1'b1;
        bus.cpu_as = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.cpu_br == 1'b0) begin
                if (grant_delay >= 0 && n == grant_delay) bus.cpu_bg = 1'b0;
                n++;
            end else begin
                n = 0;
                bus.cpu_bg = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish before 300000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        logic v;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            v = (sel == 0) ? bus.vme_dtack : bus.vme_berr;
        end while (v !== val && n < limit);
    endtask

    task automatic start_cycle(input logic [5:0] am, input logic [3:0] ah, input logic iack,
                               input logic lword, input logic a1, input logic [1:0] ds,
                               input logic wr, input int delay);
        @(negedge clock);
        grant_delay              = delay;
        bus.vme_address_mod      = am;
        bus.vme_address_high     = ah;
        bus.vme_iack             = iack;
        bus.vme_lword            = lword;
        bus.vme_a1               = a1;
        bus.vme_write            = wr;
        bus.vme_as               = 1'b0;
        @(negedge clock);
        bus.vme_ds               = ds;
    endtask

    task automatic end_cycle();
        @(negedge clock);
        bus.vme_ds = 2'b11;
        bus.vme_as = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic run_ok(input logic [5:0] am, input logic lword, input logic a1,
                          input logic [1:0] ds, input logic wr, input int delay,
                          input logic [3:0] rds);
        int n;
        exp_q.push_back('{is_berr: 1'b0, ram_ds: rds, ram_write: wr, data_dir: !wr,
                          br_cycles: delay + 1});
        start_cycle(am, 4'h2, 1'b1, lword, a1, ds, wr, delay);
        wait_sig(0, 1'b0, 200, n);
        check("dtack_seen", 32'(bus.vme_dtack), 0);
        repeat (2) @(negedge clock);
        check("dtack_held", 32'(bus.vme_dtack), 0);
        bus.vme_ds = 2'b11;
        wait_sig(0, 1'b1, 20, n);
        check("dtack_release_cycles", n, 3);
        check("release_all_negated", 32'(outs), 32'hFFF);
        end_cycle();
    endtask

    task automatic run_err(input logic lword, input logic a1, input logic [1:0] ds, input int delay);
        int n;
        exp_q.push_back('{is_berr: 1'b1, ram_ds: 4'hF, ram_write: 1'b1, data_dir: 1'b1,
                          br_cycles: (delay < 0) ? GT : delay + 1});
        start_cycle(6'h3D, 4'h2, 1'b1, lword, a1, ds, 1'b1, delay);
        wait_sig(1, 1'b0, 200, n);
        check("berr_seen", 32'(bus.vme_berr), 0);
        repeat (2) @(negedge clock);
        check("berr_held", 32'(bus.vme_berr), 0);
        bus.vme_ds = 2'b11;
        wait_sig(1, 1'b1, 20, n);
        check("berr_release_cycles", n, 3);
        end_cycle();
    endtask

    // Unselected cycle; address then flips to a valid one while AS stays low, which must still be ignored.
    task automatic run_nosel(input logic [5:0] am, input logic [3:0] ah, input logic iack);
        activity = 1'b0;
        start_cycle(am, ah, iack, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        repeat (10) @(negedge clock);
        bus.vme_address_high = 4'h2;
        bus.vme_address_mod  = 6'h3D;
        bus.vme_iack         = 1'b1;
        repeat (10) @(negedge clock);
        check("nosel_quiet", 32'(activity), 0);
        end_cycle();
    endtask

    initial begin : stim
        int n;
        bus.vme_as           = 1'b1;
        bus.vme_ds           = 2'b11;
        bus.vme_lword        = 1'b1;
        bus.vme_write        = 1'b1;
        bus.vme_iack         = 1'b1;
        bus.vme_address_mod  = 6'h00;
        bus.vme_address_high = 4'h0;
        bus.vme_a1           = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'(outs), 32'hFFF);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("idle_outputs", 32'(outs), 32'hFFF);

        run_ok(6'h3D, 1'b0, 1'b0, 2'b00, 1'b0, 3, 4'b0000);   // D32 write
        run_ok(6'h39, 1'b1, 1'b1, 2'b10, 1'b1, 3, 4'b1110);   // D8 odd read, upper half
        run_ok(6'h3A, 1'b1, 1'b0, 2'b00, 1'b0, 0, 4'b0011);   // D16 write, lower address
        run_ok(6'h3E, 1'b1, 1'b0, 2'b01, 1'b1, 1, 4'b0111);   // D8 read, byte 0
        run_ok(6'h3D, 1'b1, 1'b1, 2'b01, 1'b0, 2, 4'b1101);   // D8 write, byte 2

        run_nosel(6'h3D, 4'h5, 1'b1);
        run_nosel(6'h2D, 4'h2, 1'b1);
        run_nosel(6'h3D, 4'h2, 1'b0);

        run_err(1'b0, 1'b1, 2'b00, 2);    // lword with A1 set
        run_err(1'b0, 1'b0, 2'b01, 1);    // lword with one strobe
        run_err(1'b1, 1'b0, 2'b00, -1);   // grant never arrives

        // Reset asserted while DTACK is out, AS/DS left low across release.
        exp_q.push_back('{is_berr: 1'b0, ram_ds: 4'b0000, ram_write: 1'b0, data_dir: 1'b1,
                          br_cycles: 3});
        start_cycle(6'h3D, 4'h2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2);
        wait_sig(0, 1'b0, 200, n);
        check("dtack_before_reset", 32'(bus.vme_dtack), 0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", 32'(outs), 32'hFFF);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        activity = 1'b0;
        repeat (20) @(negedge clock);
        check("no_response_after_reset", 32'(activity), 0);
        end_cycle();

        run_ok(6'h39, 1'b1, 1'b1, 2'b10, 1'b1, 3, 4'b1110);   // fresh cycle after reset

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
